nes_controller_mux: RTL and testbench

- Parametrised, system-clocked successor to the single NES pad shift register.
- Emulates CHANNELS independent controller ports of WIDTH bits each: NES is 8, SNES is 16.
- The host latch and per-port host clock lines are treated as asynchronous data, not as clocks. They are synchronised, edge-detected and applied to per-channel shift registers on clk_i.
- Sits between the button-sampling logic (active-low buttons) and the console-facing pad pins.

---
 rtl/nes_controller_mux.sv | 94 +++++++++
 tb/tb_nes_controller_mux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_mux.sv
// Multi-channel NES/SNES controller shift-register emulator.
// The host latch and per-port host clocks are asynchronous pins. They are
// synchronised, edge-detected and applied to per-channel shift registers on clk_i.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   buttons_ni     active-low buttons; channel c at [c*WIDTH +: WIDTH], MSB shifted out first
//   latch_i        host latch (asynchronous), shared by all channels
//   pclk_i         host shift clocks (asynchronous), one per channel
//   serial_no      active-low serial data per channel, straight from the shift register MSB
//   done_o         high once WIDTH shifts have occurred since the last latch
//   latch_pulse_o  one-cycle pulse per synchronised rising edge of latch_i
module nes_controller_mux #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        FILL_BIT    = 1'b0,
    parameter logic        CLK_IDLE    = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [CHANNELS*WIDTH-1:0]    buttons_ni,
    input  logic                         latch_i,
    input  logic [CHANNELS-1:0]          pclk_i,
    output logic [CHANNELS-1:0]          serial_no,
    output logic [CHANNELS-1:0]          done_o,
    output logic                         latch_pulse_o
);

    localparam int unsigned    CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [SYNC_STAGES-1:0] lat_sync_q;
    logic                   lat_d_q;
    logic                   lat_s;

    assign lat_s = lat_sync_q[SYNC_STAGES-1];

    // Latch synchroniser, edge-detect delay flop and registered latch pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_sync_q    <= '0;
            lat_d_q       <= 1'b0;
            latch_pulse_o <= 1'b0;
        end else begin
            lat_sync_q    <= {lat_sync_q[SYNC_STAGES-2:0], latch_i};
            lat_d_q       <= lat_s;
            latch_pulse_o <= lat_s & ~lat_d_q;
        end
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        logic [SYNC_STAGES-1:0] pclk_sync_q;
        logic                   pclk_d_q;
        logic [WIDTH-1:0]       sreg_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   done_q;
        logic                   shift_c;

        // Latch level has priority: a pclk edge coinciding with lat_s is dropped.
        assign shift_c = ~lat_s & pclk_sync_q[SYNC_STAGES-1] & ~pclk_d_q;

        // Per-channel pclk synchroniser, shift register and saturating bit counter.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pclk_sync_q <= {SYNC_STAGES{CLK_IDLE}};
                pclk_d_q    <= CLK_IDLE;
                sreg_q      <= '1;
                cnt_q       <= '0;
                done_q      <= 1'b0;
            end else begin
                pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], pclk_i[c]};
                pclk_d_q    <= pclk_sync_q[SYNC_STAGES-1];
                if (lat_s) begin
                    sreg_q <= buttons_ni[c*WIDTH +: WIDTH];
                    cnt_q  <= '0;
                    done_q <= 1'b0;
                end else if (shift_c) begin
                    sreg_q <= {sreg_q[WIDTH-2:0], FILL_BIT};
                    // done tracks the counter's next value so it reads cnt_q == WIDTH
                    if (cnt_q != CNT_MAX) begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        done_q <= (cnt_q == CNT_MAX - CNT_W'(1));
                    end
                end
            end
        end

        assign serial_no[c] = sreg_q[WIDTH-1];
        assign done_o[c]    = done_q;
    end

endmodule

// File: tb/tb_nes_controller_mux.sv
module tb_nes_controller_mux;

    logic        clk;
    logic        rst_n;

    // 8-bit, 2-channel instance (NES)
    logic [15:0] btn_a;
    logic        latch_a;
    logic [1:0]  pclk_a;
    logic [1:0]  serial_a;
    logic [1:0]  done_a;
    logic        lp_a;

    // 16-bit, 1-channel instance (SNES)
    logic [15:0] btn_b;
    logic        latch_b;
    logic [0:0]  pclk_b;
    logic [0:0]  serial_b;
    logic [0:0]  done_b;
    logic        lp_b;

    int checks   = 0;
    int failures = 0;
    int lp_cnt_a = 0;
    int lp_cnt_b = 0;
    int s1_low_a = 0;

    nes_controller_mux #(.WIDTH(8), .CHANNELS(2), .SYNC_STAGES(2),
                         .FILL_BIT(1'b0), .CLK_IDLE(1'b1)) u_dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .buttons_ni   (btn_a),
        .latch_i      (latch_a),
        .pclk_i       (pclk_a),
        .serial_no    (serial_a),
        .done_o       (done_a),
        .latch_pulse_o(lp_a)
    );

    nes_controller_mux #(.WIDTH(16), .CHANNELS(1), .SYNC_STAGES(2),
                         .FILL_BIT(1'b0), .CLK_IDLE(1'b1)) u_dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .buttons_ni   (btn_b),
        .latch_i      (latch_b),
        .pclk_i       (pclk_b),
        .serial_no    (serial_b),
        .done_o       (done_b),
        .latch_pulse_o(lp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (lp_a === 1'b1) lp_cnt_a++;
        if (lp_b === 1'b1) lp_cnt_b++;
        if (serial_a[1] !== 1'b1) s1_low_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input int ch);
        pclk_a[ch] = 1'b0;
        tick(4);
        pclk_a[ch] = 1'b1;
        tick(4);
    endtask

    task automatic pulse_b();
        pclk_b[0] = 1'b0;
        tick(4);
        pclk_b[0] = 1'b1;
        tick(4);
    endtask

    task automatic latch_dut_a();
        latch_a = 1'b1;
        tick(12);
        latch_a = 1'b0;
        tick(6);
    endtask

    // Full NES read of channel 0 with buttons {FF, 7E}.
    task automatic nes_read(input string tag);
        logic [7:0] pat;
        int         lp0;
        int         s10;
        pat   = 8'h7E;
        btn_a = {8'hFF, 8'h7E};
        lp0   = lp_cnt_a;
        s10   = s1_low_a;
        latch_dut_a();
        chk({tag, "_latch_pulses"}, 32'(lp_cnt_a - lp0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(serial_a[0]), 32'(pat[7-i]));
            if (i == 7) chk({tag, "_done_before_8th"}, 32'(done_a), 32'd0);
            pulse_a(0);
        end
        chk({tag, "_fill"}, 32'(serial_a[0]), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'b01);
        chk({tag, "_ch1_high"}, 32'(s1_low_a - s10), 32'd0);
    endtask

    initial begin
        int lp0;
        logic [15:0] pb;
        rst_n   = 1'b1;
        btn_a   = 16'hFFFF;
        btn_b   = 16'hFFFF;
        latch_a = 1'b0;
        latch_b = 1'b0;
        pclk_a  = 2'b11;
        pclk_b  = 1'b1;

        // 1. Reset asserted between edges takes effect immediately
        tick(2);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_serial_a", 32'(serial_a), 32'b11);
        chk("rst_done_a", 32'(done_a), 32'b00);
        chk("rst_lp_a", 32'(lp_a), 32'd0);
        chk("rst_serial_b", 32'(serial_b), 32'd1);
        tick(2);
        rst_n = 1'b1;
        lp0 = lp_cnt_a;
        tick(6);
        chk("rel_serial_a", 32'(serial_a), 32'b11);
        chk("rel_done_a", 32'(done_a), 32'b00);
        chk("rel_no_pulse", 32'(lp_cnt_a - lp0), 32'd0);

        // 2. NES read
        nes_read("nes");

        // 3. SNES 16-bit read, with one extra edge past WIDTH
        pb      = 16'h5FFF;
        btn_b   = pb;
        lp0     = lp_cnt_b;
        latch_b = 1'b1;
        tick(12);
        latch_b = 1'b0;
        tick(6);
        chk("snes_latch_pulses", 32'(lp_cnt_b - lp0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("snes_bit%0d", i), 32'(serial_b), 32'(pb[15-i]));
            if (i == 15) chk("snes_done_before_16th", 32'(done_b), 32'd0);
            pulse_b();
        end
        chk("snes_done16", 32'(done_b), 32'd1);
        chk("snes_fill16", 32'(serial_b), 32'd0);
        pulse_b();
        chk("snes_done17", 32'(done_b), 32'd1);
        chk("snes_fill17", 32'(serial_b), 32'd0);

        // 4. Latch priority over a coincident pclk edge, buttons mirrored mid-latch
        btn_a     = 16'hFFFF;
        pclk_a[0] = 1'b0;
        tick(4);
        latch_a   = 1'b1;
        pclk_a[0] = 1'b1;
        tick(5);
        chk("prio_mirror_ff", 32'(serial_a[0]), 32'd1);
        btn_a[7:0] = 8'h00;
        tick(5);
        chk("prio_mirror_00", 32'(serial_a[0]), 32'd0);
        latch_a = 1'b0;
        tick(6);
        chk("prio_serial", 32'(serial_a[0]), 32'd0);
        chk("prio_done", 32'(done_a), 32'b00);
        for (int i = 0; i < 7; i++) pulse_a(0);
        chk("prio_cnt_7", 32'(done_a), 32'b00);
        pulse_a(0);
        chk("prio_cnt_8", 32'(done_a), 32'b01);

        // 5. Channel independence: only channel 1 is clocked
        btn_a = {8'h0F, 8'hF0};
        latch_dut_a();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ind_ch1_bit%0d", i), 32'(serial_a[1]), 32'd0);
            pulse_a(1);
        end
        chk("ind_ch1_after", 32'(serial_a[1]), 32'd1);
        chk("ind_ch0_held", 32'(serial_a[0]), 32'd1);
        chk("ind_done", 32'(done_a), 32'b00);

        // 6. Reset in the middle of a read, then a clean read
        btn_a = {8'hFF, 8'h7E};
        latch_dut_a();
        for (int i = 0; i < 3; i++) pulse_a(0);
        chk("mid_bit3", 32'(serial_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", 32'(serial_a), 32'b11);
        chk("mid_rst_done", 32'(done_a), 32'b00);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        nes_read("reread");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
